// File: rtl/regfile_param_clr_if.sv
// Register-file access bundle: two combinational read ports, one write port,
// clear request and the busy/wr_drop status returned by the register file.
interface regfile_param_clr_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_data;
  logic              we;
  logic              clr_req;
  logic              busy;
  logic              wr_drop;

  modport master (
    output a_addr, b_addr, d_addr, d_data, we, clr_req,
    input  a_data, b_data, busy, wr_drop
  );

  modport slave (
    input  a_addr, b_addr, d_addr, d_data, we, clr_req,
    output a_data, b_data, busy, wr_drop
  );
endinterface

// File: rtl/regfile_param_clr.sv
// 2R/1W register file, zero-latency reads, optional hardwired R0, sequenced clear (busy=DEPTH cycles);
// writes during busy are dropped and flagged on wr_drop. REGF_BYPASS_EN enables write-to-read forwarding.
module regfile_param_clr #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  regfile_param_clr_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              clearing;
  logic              cnt_last;
  logic              wr_acc;
  logic              wr_drop_q;
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;

  assign cnt_last = (cnt == ADDR_W'(DEPTH - 1));
  assign clearing = (state == CLEAR);

  // R0 writes are swallowed without raising wr_drop when it is hardwired.
  assign wr_acc = bus.we && !clearing && !(ZERO_REG && (bus.d_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (clearing) begin
        regs[cnt] <= '0;
      end
      if (wr_acc) begin
        regs[bus.d_addr] <= bus.d_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= bus.we && clearing;
    end
  end

  always_comb begin
    a_val = regs[bus.a_addr];
    b_val = regs[bus.b_addr];
    if (ZERO_REG && (bus.a_addr == '0)) begin
      a_val = '0;
    end
    if (ZERO_REG && (bus.b_addr == '0)) begin
      b_val = '0;
    end
`ifdef REGF_BYPASS_EN
    // wr_acc already excludes CLEAR and the hardwired R0, so those never forward.
    if (wr_acc && (bus.a_addr == bus.d_addr)) begin
      a_val = bus.d_data;
    end
    if (wr_acc && (bus.b_addr == bus.d_addr)) begin
      b_val = bus.d_data;
    end
`endif
  end

  assign bus.a_data  = a_val;
  assign bus.b_data  = b_val;
  assign bus.busy    = clearing;
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_regfile_param_clr.sv
// Directed + randomized bench for regfile_param_clr against an array-based reference model.
module tb_regfile_param_clr;
  logic clk = 1'b0;
  logic rst_n;

  regfile_param_clr_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  regfile_param_clr #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: register contents plus "how many registers are left to clear".
  logic [7:0] mr [8];
  int         clear_left;
  int         clear_next;
  logic       m_drop;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mr[i] = 8'h00;
    clear_left = 0;
    clear_next = 0;
    m_drop     = 1'b0;
  endtask

  task automatic model_edge();
    logic acc;
    logic drop;
    acc  = bus.we && (clear_left == 0) && (bus.d_addr != 3'd0);
    drop = bus.we && (clear_left != 0);
    if (clear_left > 0) begin
      mr[clear_next] = 8'h00;
      clear_next     = clear_next + 1;
      clear_left     = clear_left - 1;
    end else if (bus.clr_req) begin
      clear_left = 8;
      clear_next = 0;
    end
    if (acc) mr[bus.d_addr] = bus.d_data;
    m_drop = drop;
  endtask

  function automatic logic [7:0] exp_read(input logic [2:0] addr);
    if (addr == 3'd0) return 8'h00;
`ifdef REGF_BYPASS_EN
    if (bus.we && (clear_left == 0) && (bus.d_addr == addr)) return bus.d_data;
`endif
    return mr[addr];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/a_data"},  32'(bus.a_data),  32'(exp_read(bus.a_addr)));
    chk({tag, "/b_data"},  32'(bus.b_data),  32'(exp_read(bus.b_addr)));
    chk({tag, "/busy"},    32'(bus.busy),    32'(clear_left > 0));
    chk({tag, "/wr_drop"}, 32'(bus.wr_drop), 32'(m_drop));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic cyc(input string tag);
    #1;
    check_all(tag);
    tick();
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] data);
    bus.we     = 1'b1;
    bus.d_addr = addr;
    bus.d_data = data;
    cyc("write");
    bus.we = 1'b0;
  endtask

  task automatic count_busy(input int cycles, output int nb);
    nb = 0;
    for (int i = 0; i < cycles; i++) begin
      bus.a_addr = 3'($urandom_range(0, 7));
      bus.b_addr = 3'($urandom_range(0, 7));
      #1;
      if (bus.busy === 1'b1) nb = nb + 1;
      check_all("clear_run");
      tick();
    end
  endtask

  int nb;
  int nb2;

  initial begin
    rst_n       = 1'b0;
    bus.a_addr  = '0;
    bus.b_addr  = '0;
    bus.d_addr  = '0;
    bus.d_data  = '0;
    bus.we      = 1'b0;
    bus.clr_req = 1'b0;
    model_reset();
    #2;
    check_all("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset contents on every address.
    for (int i = 0; i < 8; i++) begin
      bus.a_addr = 3'(i);
      bus.b_addr = 3'(7 - i);
      cyc("reset_read");
    end

    // Basic writes and the hardwired R0.
    wr(3'd3, 8'hA5);
    wr(3'd7, 8'h3C);
    bus.a_addr = 3'd3;
    bus.b_addr = 3'd7;
    #1;
    chk("r3_read", 32'(bus.a_data), 32'hA5);
    chk("r7_read", 32'(bus.b_data), 32'h3C);
    tick();
    wr(3'd0, 8'hFF);
    bus.a_addr = 3'd0;
    #1;
    chk("r0_zero", 32'(bus.a_data), 32'h00);
    chk("r0_no_drop", 32'(bus.wr_drop), 32'h0);
    tick();

    // Fill, one-cycle clear pulse, busy lasts exactly DEPTH cycles.
    for (int i = 1; i < 8; i++) wr(3'(i), 8'(8'h10 + i));
    bus.clr_req = 1'b1;
    cyc("clr_pulse");
    bus.clr_req = 1'b0;
    count_busy(12, nb);
    chk("busy_len", 32'(nb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      bus.a_addr = 3'(i);
      bus.b_addr = 3'(i);
      cyc("post_clear");
    end

    // Write and second clr_req during CLEAR are both ignored.
    wr(3'd5, 8'h42);
    bus.clr_req = 1'b1;
    cyc("clr_pulse2");
    bus.clr_req = 1'b0;
    count_busy(2, nb);
    bus.we      = 1'b1;
    bus.d_addr  = 3'd5;
    bus.d_data  = 8'h77;
    bus.clr_req = 1'b1;
    #1;
    if (bus.busy === 1'b1) nb = nb + 1;
    check_all("write_in_clear");
    tick();
    bus.we      = 1'b0;
    bus.clr_req = 1'b0;
    #1;
    chk("wr_drop_pulse", 32'(bus.wr_drop), 32'h1);
    count_busy(12, nb2);
    chk("busy_len_noretrig", 32'(nb + nb2), 32'd8);
    bus.a_addr = 3'd5;
    #1;
    chk("r5_after_clear", 32'(bus.a_data), 32'h00);
    tick();

    // Reset in the middle of a clear, then a full clear afterwards.
    wr(3'd6, 8'h11);
    wr(3'd4, 8'h99);
    bus.clr_req = 1'b1;
    cyc("clr_pulse3");
    bus.clr_req = 1'b0;
    count_busy(3, nb);
    rst_n = 1'b0;
    model_reset();
    bus.a_addr = 3'd6;
    bus.b_addr = 3'd4;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'h0);
    chk("rst_mid_r6", 32'(bus.a_data), 32'h00);
    check_all("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wr(3'd6, 8'h11);
    bus.clr_req = 1'b1;
    cyc("clr_pulse4");
    bus.clr_req = 1'b0;
    count_busy(12, nb);
    chk("busy_len_after_rst", 32'(nb), 32'd8);

    // clr_req held high: clears back-to-back with one IDLE cycle between.
    wr(3'd2, 8'hC3);
    bus.clr_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.a_addr = 3'($urandom_range(0, 7));
      bus.b_addr = 3'd2;
      cyc("clr_held");
    end
    bus.clr_req = 1'b0;
    count_busy(10, nb);

    // Same-cycle write/read of R2.
    wr(3'd2, 8'h11);
    bus.we     = 1'b1;
    bus.d_addr = 3'd2;
    bus.d_data = 8'h5A;
    bus.a_addr = 3'd2;
    bus.b_addr = 3'd3;
    #1;
`ifdef REGF_BYPASS_EN
    chk("same_cycle_read", 32'(bus.a_data), 32'h5A);
`else
    chk("same_cycle_read", 32'(bus.a_data), 32'h11);
`endif
    check_all("same_cycle");
    tick();
    bus.we = 1'b0;
    #1;
    chk("next_cycle_read", 32'(bus.a_data), 32'h5A);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      bus.we      = 1'($urandom_range(0, 1));
      bus.d_addr  = 3'($urandom_range(0, 7));
      bus.d_data  = 8'($urandom_range(0, 255));
      bus.a_addr  = ($urandom_range(0, 3) == 0) ? bus.d_addr : 3'($urandom_range(0, 7));
      bus.b_addr  = 3'($urandom_range(0, 7));
      bus.clr_req = ($urandom_range(0, 19) == 0);
      cyc("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
